uart_rx_core: RTL and testbench

Serial UART receiver: recovers 8N1-style frames from the asynchronous `rx` line using a 16x oversampling tick. It sits on the receive side of the UART peripheral, downstream of the baud generator's receive tick. It presents each recovered byte through a single-entry holding register with a valid/ready handshake toward the bus-side logic.

---
 rtl/uart_rx_core.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core
// Receive half of the UART. It recovers DBIT-bit, LSB-first frames from the
// asynchronous rx line. Bit timing comes from a 16x oversampling tick.
// Each completed byte is presented through a single-entry holding register
// with a valid/ready handshake.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous, active-high reset
//   s_tick     one-cycle enable pulse at 16x the baud rate
//   rx         asynchronous serial input, idle high
//   rx_data    last accepted byte, stable while rx_valid is high
//   rx_valid   holding register full
//   rx_ready   consumer takes the byte when rx_valid && rx_ready
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: completed byte dropped, holding register full
//
// Parameters:
//   DBIT       data bits per frame, 5..8
//   SB_TICK    oversample ticks spent in the stop bit (16 = one stop bit)

module uart_rx_core #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            overrun
);

  // The tick counter is normally 4 bits wide. It widens only when the stop
  // period is longer than one bit, so that SB_TICK-1 stays reachable.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

  localparam logic [SW-1:0] S_MID      = SW'(7);
  localparam logic [SW-1:0] S_BIT_END  = SW'(15);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST     = 3'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state, state_n;
  logic [SW-1:0]   s_cnt, s_cnt_n;
  logic [2:0]      n_cnt, n_cnt_n;
  logic [DBIT-1:0] b_reg, b_reg_n;
  logic            rx_meta, rx_s;
  logic            stop_done;
  logic            stop_ok;

  // Two-flop synchronizer on the raw line. Both flops reset to the idle
  // (high) level, so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counter and shift register storage. All next values come from
  // the combinational block below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s_cnt <= '0;
      n_cnt <= '0;
      b_reg <= '0;
    end else begin
      state <= state_n;
      s_cnt <= s_cnt_n;
      n_cnt <= n_cnt_n;
      b_reg <= b_reg_n;
    end
  end

  // Frame sequencing. A start bit is confirmed half a bit after the falling
  // edge, so every later sample lands near the middle of its bit. stop_done
  // marks the tick that closes the stop bit. stop_ok tells whether the line
  // was high at that tick.
  always_comb begin
    state_n   = state;
    s_cnt_n   = s_cnt;
    n_cnt_n   = n_cnt;
    b_reg_n   = b_reg;
    stop_done = 1'b0;
    stop_ok   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_cnt_n = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == S_MID) begin
            if (!rx_s) begin
              state_n = DATA;
              s_cnt_n = '0;
              n_cnt_n = '0;
            end else begin
              // Line went back high before mid start bit: treat it as noise.
              state_n = IDLE;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == S_BIT_END) begin
            b_reg_n = {rx_s, b_reg[DBIT-1:1]};
            s_cnt_n = '0;
            if (n_cnt == N_LAST) begin
              state_n = STOP;
            end else begin
              n_cnt_n = n_cnt + 1'b1;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == S_STOP_END) begin
            stop_done = 1'b1;
            stop_ok   = rx_s;
            state_n   = rx_s ? IDLE : BREAK;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      BREAK: begin
        // Wait out a held-low line so that a break reports only one error.
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Holding register and status pulses. A new byte may replace the held one
  // only when the consumer takes the old one in the same cycle. Otherwise
  // the new byte is dropped and overrun is flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_done && !stop_ok;
      overrun   <= 1'b0;
      if (stop_done && stop_ok) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= b_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
// Bench for uart_rx_core. It drives serial frames into two instances: the
// default 8N1 build, and a DBIT=7 / SB_TICK=32 build.
// Expected bytes, valid state and error counts come from a small
// holding-register model. Delivery timing is predicted from the frame length
// in ticks.

module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  logic       rx7;
  logic       rx_ready7;
  logic [6:0] rx_data7;
  logic       rx_valid7;
  logic       frame_err7;
  logic       overrun7;

  int total;
  int bad;

  int   stepIdx;
  int   phase;
  int   feCnt;
  int   ovCnt;
  int   dropCnt;
  int   riseStep;
  logic prevValid;
  int   feCnt7;
  int   riseStep7;
  logic prevValid7;
  int   deliverStep;

  logic [7:0] mData;
  logic       mValid;
  int         mFe;
  int         mOv;

  always #5 clk = ~clk;

  uart_rx_core dut (
    .clk       (clk),
    .reset     (reset),
    .s_tick    (s_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  uart_rx_core #(.DBIT(7), .SB_TICK(32)) dut7 (
    .clk       (clk),
    .reset     (reset),
    .s_tick    (s_tick),
    .rx        (rx7),
    .rx_data   (rx_data7),
    .rx_valid  (rx_valid7),
    .rx_ready  (rx_ready7),
    .frame_err (frame_err7),
    .overrun   (overrun7)
  );

  // One comparison: counts it, and reports a failure with tag and values.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge. This samples what the last rising
  // edge produced, then sets s_tick for the coming edge (every 4th clock).
  task automatic step();
    @(negedge clk);
    stepIdx++;
    if (frame_err) feCnt++;
    if (overrun) ovCnt++;
    if (rx_valid && !prevValid) riseStep = stepIdx;
    if (!rx_valid && prevValid) dropCnt++;
    prevValid = rx_valid;
    if (frame_err7) feCnt7++;
    if (rx_valid7 && !prevValid7) riseStep7 = stepIdx;
    prevValid7 = rx_valid7;
    phase  = (phase + 1) % 4;
    s_tick = (phase == 0);
  endtask

  // Hold a line level for a number of ticks.
  task automatic holdLine(input logic val, input int ticks, input bit alt);
    int n;
    n = 0;
    while (n < ticks) begin
      step();
      if (alt) rx7 = val; else rx = val;
      if (s_tick) n++;
    end
  endtask

  // Send one frame. Its length is measured in ticks from the start edge.
  // The receiver starts counting ticks three edges after the line falls
  // (two synchronizer flops plus the detect edge). It delivers on its
  // (8 + 16*nbits + stop ticks)-th counted tick. deliverStep is the step at
  // which that edge's result becomes visible. If readyAtDeliver is set,
  // rx_ready is pulsed for exactly that edge. A nonzero abortAt returns
  // early once that many ticks have been sent.
  task automatic applyStimulus(input logic [7:0] data, input int nbits,
                               input logic stopVal, input int stopTicks,
                               input bit alt, input bit readyAtDeliver,
                               input int abortAt);
    int   frameTicks;
    int   sendTicks;
    int   tIdx;
    int   dutTicks;
    bit   hit;
    logic line;
    frameTicks  = 8 + 16 * nbits + (alt ? 32 : 16);
    sendTicks   = 16 + 16 * nbits + stopTicks;
    tIdx        = 0;
    dutTicks    = 0;
    deliverStep = 0;
    for (int s = 0; ; s++) begin
      step();
      if (abortAt > 0 && tIdx >= abortAt) break;
      if (s >= 3 && s_tick) dutTicks++;
      hit = (s >= 3) && s_tick && (dutTicks == frameTicks);
      if (hit) deliverStep = stepIdx + 1;
      if (tIdx < 16) line = 1'b0;
      else if (tIdx < 16 + 16 * nbits) line = data[(tIdx - 16) / 16];
      else line = stopVal;
      if (alt) rx7 = line; else rx = line;
      if (readyAtDeliver) begin
        if (alt) rx_ready7 = hit; else rx_ready = hit;
      end
      if (s_tick) tIdx++;
      if (deliverStep > 0 && tIdx >= sendTicks && stepIdx > deliverStep) break;
      if (s > 20000) begin
        checkOutput("frame_timeout", s, 0);
        break;
      end
    end
  endtask

  // Model of a completed frame when rx_ready stays low at the delivery edge.
  task automatic modelFrame(input logic [7:0] data, input bit stopOk);
    if (!stopOk) mFe++;
    else if (mValid) mOv++;
    else begin
      mData  = data;
      mValid = 1'b1;
    end
  endtask

  // Take the held byte with a one-cycle rx_ready pulse.
  task automatic consumeByte();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    mValid   = 1'b0;
    checkOutput("valid_clear", rx_valid, 0);
  endtask

  initial begin
    logic [7:0] rb;
    int         dropSnap;
    total = 0; bad = 0;
    stepIdx = 0; phase = 0;
    feCnt = 0; ovCnt = 0; dropCnt = 0; riseStep = 0; prevValid = 1'b0;
    feCnt7 = 0; riseStep7 = 0; prevValid7 = 1'b0; deliverStep = 0;
    mData = 8'h00; mValid = 1'b0; mFe = 0; mOv = 0;
    reset = 1'b1; s_tick = 1'b0;
    rx = 1'b1; rx_ready = 1'b0; rx7 = 1'b1; rx_ready7 = 1'b0;

    // Reset state
    repeat (4) step();
    checkOutput("rst_valid", rx_valid, 0);
    checkOutput("rst_data", rx_data, 0);
    checkOutput("rst_ferr", frame_err, 0);
    checkOutput("rst_ovr", overrun, 0);
    reset = 1'b0;
    holdLine(1'b1, 4, 1'b0);

    // Normal byte, held while rx_ready is low
    applyStimulus(8'hA5, 8, 1'b1, 16, 1'b0, 1'b0, 0);
    modelFrame(8'hA5, 1'b1);
    checkOutput("a5_data", rx_data, mData);
    checkOutput("a5_valid", rx_valid, mValid);
    checkOutput("a5_latency", riseStep, deliverStep);
    holdLine(1'b1, 20, 1'b0);
    checkOutput("a5_held", rx_data, mData);
    checkOutput("a5_held_valid", rx_valid, mValid);
    consumeByte();

    // Glitch shorter than half a bit
    holdLine(1'b0, 3, 1'b0);
    holdLine(1'b1, 24, 1'b0);
    checkOutput("glitch_valid", rx_valid, 0);
    checkOutput("glitch_ferr", feCnt, mFe);
    applyStimulus(8'h3C, 8, 1'b1, 16, 1'b0, 1'b0, 0);
    modelFrame(8'h3C, 1'b1);
    checkOutput("glitch_next", rx_data, mData);
    consumeByte();

    // Bad stop bit followed by a long break
    applyStimulus(8'h55, 8, 1'b0, 16, 1'b0, 1'b0, 0);
    modelFrame(8'h55, 1'b0);
    holdLine(1'b0, 640, 1'b0);
    checkOutput("break_ferr_count", feCnt, mFe);
    checkOutput("break_valid", rx_valid, 0);
    holdLine(1'b1, 8, 1'b0);
    applyStimulus(8'h81, 8, 1'b1, 16, 1'b0, 1'b0, 0);
    modelFrame(8'h81, 1'b1);
    checkOutput("after_break_data", rx_data, mData);
    checkOutput("after_break_valid", rx_valid, mValid);
    checkOutput("after_break_ferr", feCnt, mFe);
    consumeByte();

    // Overrun, then a replacement taken on the exact delivery edge
    applyStimulus(8'h3C, 8, 1'b1, 16, 1'b0, 1'b0, 0);
    modelFrame(8'h3C, 1'b1);
    applyStimulus(8'hC3, 8, 1'b1, 16, 1'b0, 1'b0, 0);
    modelFrame(8'hC3, 1'b1);
    checkOutput("ovr_count", ovCnt, mOv);
    checkOutput("ovr_data", rx_data, mData);
    checkOutput("ovr_valid", rx_valid, mValid);
    dropSnap = dropCnt;
    applyStimulus(8'hC3, 8, 1'b1, 16, 1'b0, 1'b1, 0);
    mData = 8'hC3;
    checkOutput("swap_data", rx_data, mData);
    checkOutput("swap_valid", rx_valid, 1);
    checkOutput("swap_no_ovr", ovCnt, mOv);
    checkOutput("swap_no_drop", dropCnt, dropSnap);

    // Reset during data bit 4 of 0xFF, while a byte is still held
    applyStimulus(8'hFF, 8, 1'b1, 16, 1'b0, 1'b0, 88);
    reset = 1'b1;
    #1;
    mValid = 1'b0;
    mData  = 8'h00;
    checkOutput("midrst_valid", rx_valid, mValid);
    checkOutput("midrst_data", rx_data, mData);
    checkOutput("midrst_ferr", frame_err, 0);
    checkOutput("midrst_ovr", overrun, 0);
    rx = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    holdLine(1'b1, 40, 1'b0);
    checkOutput("midrst_no_spurious", rx_valid, 0);
    applyStimulus(8'h5A, 8, 1'b1, 16, 1'b0, 1'b0, 0);
    modelFrame(8'h5A, 1'b1);
    checkOutput("midrst_next_data", rx_data, mData);
    checkOutput("midrst_next_latency", riseStep, deliverStep);
    consumeByte();

    // Random bytes, with a random choice of whether to take each one
    for (int i = 0; i < 5; i++) begin
      rb = 8'($urandom_range(0, 255));
      applyStimulus(rb, 8, 1'b1, 16, 1'b0, 1'b0, 0);
      modelFrame(rb, 1'b1);
      checkOutput("rand_data", rx_data, mData);
      checkOutput("rand_valid", rx_valid, mValid);
      checkOutput("rand_ovr", ovCnt, mOv);
      if ($urandom_range(0, 1) == 1) consumeByte();
      holdLine(1'b1, 4, 1'b0);
    end

    // Seven data bits with a two-bit stop period
    applyStimulus(8'h4B, 7, 1'b1, 32, 1'b1, 1'b0, 0);
    checkOutput("p7_data", {1'b0, rx_data7}, 8'h4B);
    checkOutput("p7_valid", rx_valid7, 1);
    checkOutput("p7_latency", riseStep7, deliverStep);
    checkOutput("p7_ferr", feCnt7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
